// File: rtl/program_store_pkg.sv
// Shared opcode constants, default fill word and FSM state type for the
// writable program store.
package program_store_pkg;

    localparam logic [4:0] OPCODE_NOP  = 5'h10;
    localparam logic [4:0] OPCODE_LDI  = 5'h01;
    localparam logic [4:0] OPCODE_ADD  = 5'h02;
    localparam logic [4:0] OPCODE_JMP  = 5'h03;
    localparam logic [4:0] OPCODE_HALT = 5'h1F;

    localparam logic [12:0] NOP_WORD_DEF = {OPCODE_NOP, 8'h00};

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/program_store_if.sv
// Fetch and byte-load signal bundle between the core/host and the program store.
interface program_store_if #(
    parameter int ADDR_W = 6,
    parameter int INS_W  = 13
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic              busy;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        load_byte;
    logic              load_byte_valid;
    logic              load_byte_ready;
    logic              load_done;
    logic              load_err;

    modport master (
        output fetch_req, fetch_addr, load_start, load_base, load_len,
               load_byte, load_byte_valid,
        input  ins_out, ins_valid, busy, load_byte_ready, load_done, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base, load_len,
               load_byte, load_byte_valid,
        output ins_out, ins_valid, busy, load_byte_ready, load_done, load_err
    );
endinterface

// File: rtl/program_store_prog_mem_array.sv
// Single-port instruction array: synchronous write, registered read whose
// output register holds between reads and resets to RST_VAL.
module prog_mem_array #(
    parameter int                ADDR_W  = 6,
    parameter int                INS_W   = 13,
    parameter logic [INS_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [INS_W-1:0]  wdata,
    output logic [INS_W-1:0]  rdata
);
    logic [INS_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= RST_VAL;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/program_store.sv
// Writable program store: self-clears to NOP after reset, serves registered
// fetches in RUN, and assembles little-endian byte streams into words in LOAD.
module program_store
    import program_store_pkg::*;
#(
    parameter int               ADDR_W   = 6,
    parameter int               INS_W    = 13,
    parameter logic [INS_W-1:0] NOP_WORD = INS_W'(NOP_WORD_DEF)
) (
    input logic             clk,
    input logic             rst,
    program_store_if.slave  bus
);
    localparam int BPW  = (INS_W + 7) / 8;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr, base_q, mem_addr;
    logic [ADDR_W:0]     len_q, wcnt;
    logic [BI_W-1:0]     bidx;
    logic [BPW*8-1:0]    acc, word_full;
    logic [INS_W-1:0]    mem_wdata;
    logic                mem_we, mem_re, byte_acc, word_done, last_word, len_bad;

    assign len_bad = (bus.load_len == '0) || (bus.load_len > DEPTH_L);

    always_comb begin
        state_d             = state_q;
        mem_we              = 1'b0;
        mem_re              = 1'b0;
        mem_addr            = bus.fetch_addr;
        mem_wdata           = NOP_WORD;
        bus.busy            = 1'b1;
        bus.load_byte_ready = 1'b0;
        byte_acc            = 1'b0;
        word_done           = 1'b0;
        last_word           = (wcnt == len_q - 1'b1);
        // The final byte goes straight to the write port on its accepting edge.
        word_full                  = acc;
        word_full[(BPW-1)*8 +: 8]  = bus.load_byte;
        case (state_q)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_ptr;
                if (clr_ptr == '1) state_d = RUN;
            end
            RUN: begin
                bus.busy = 1'b0;
                mem_re   = bus.fetch_req;
                if (bus.load_start && !len_bad) state_d = LOAD;
            end
            LOAD: begin
                bus.load_byte_ready = 1'b1;
                byte_acc  = bus.load_byte_valid;
                word_done = byte_acc && (bidx == BI_W'(BPW - 1));
                mem_addr  = base_q + wcnt[ADDR_W-1:0];
                mem_we    = word_done;
                mem_wdata = INS_W'(word_full);
                if (word_done && last_word) state_d = RUN;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_ptr       <= '0;
            base_q        <= '0;
            len_q         <= '0;
            wcnt          <= '0;
            bidx          <= '0;
            acc           <= '0;
            bus.ins_valid <= 1'b0;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.ins_valid <= (state_q == RUN) && bus.fetch_req;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
            if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (state_q == RUN && bus.load_start) begin
                if (len_bad) begin
                    bus.load_err <= 1'b1;
                end else begin
                    base_q <= bus.load_base;
                    len_q  <= bus.load_len;
                    wcnt   <= '0;
                    bidx   <= '0;
                end
            end
            if (byte_acc) begin
                if (word_done) begin
                    bidx          <= '0;
                    wcnt          <= wcnt + 1'b1;
                    bus.load_done <= last_word;
                end else begin
                    acc[8*bidx +: 8] <= bus.load_byte;
                    bidx             <= bidx + 1'b1;
                end
            end
        end
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .INS_W  (INS_W),
        .RST_VAL(NOP_WORD)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(bus.ins_out)
    );
endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: reference memory model plus a queue of
// expected fetch results popped when ins_valid is observed.
module tb_program_store;
    localparam int ADDR_W = 6;
    localparam int INS_W  = 13;
    localparam int DEPTH  = 64;
    localparam logic [INS_W-1:0] NOP = 13'h1000;

    logic clk, rst;
    program_store_if #(.ADDR_W(ADDR_W), .INS_W(INS_W)) bus ();

    program_store #(.ADDR_W(ADDR_W), .INS_W(INS_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [INS_W-1:0] mem_m [DEPTH];
    logic [INS_W-1:0] exp_q [$];
    logic [INS_W-1:0] last_ins;
    logic [7:0]       lb [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic fetch_seq(input int a0, input int n);
        logic [INS_W-1:0] e;
        for (int i = 0; i < n; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = ADDR_W'((a0 + i) % DEPTH);
            exp_q.push_back(mem_m[(a0 + i) % DEPTH]);
            tick();
            chk("fetch_valid", {31'd0, bus.ins_valid}, 32'd1);
            if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk($sformatf("fetch_data[%0d]", (a0 + i) % DEPTH), {19'd0, bus.ins_out}, {19'd0, e});
            end
            last_ins = bus.ins_out;
        end
        bus.fetch_req = 1'b0;
        tick();
        chk("fetch_idle_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk("fetch_idle_hold", {19'd0, bus.ins_out}, {19'd0, last_ins});
    endtask

    task automatic do_load(input int base, input int len, input bit gaps, input bit fetch_during);
        logic [15:0] t;
        int nb;
        nb = 2 * len;
        bus.load_start = 1'b1;
        bus.load_base  = ADDR_W'(base);
        bus.load_len   = (ADDR_W+1)'(len);
        tick();
        bus.load_start = 1'b0;
        chk("load_busy", {31'd0, bus.busy}, 32'd1);
        chk("load_ready", {31'd0, bus.load_byte_ready}, 32'd1);
        for (int i = 0; i < nb; i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.load_byte_valid = 1'b0;
                tick();
                chk("gap_no_done", {31'd0, bus.load_done}, 32'd0);
            end
            bus.load_byte_valid = 1'b1;
            bus.load_byte       = lb[i];
            if (fetch_during) begin
                bus.fetch_req  = 1'b1;
                bus.fetch_addr = ADDR_W'(i);
            end
            tick();
            if (fetch_during) begin
                chk("load_fetch_valid", {31'd0, bus.ins_valid}, 32'd0);
                chk("load_fetch_hold", {19'd0, bus.ins_out}, {19'd0, last_ins});
            end
            if (i < nb - 1) chk("early_done", {31'd0, bus.load_done}, 32'd0);
        end
        bus.load_byte_valid = 1'b0;
        bus.fetch_req       = 1'b0;
        chk("done_pulse", {31'd0, bus.load_done}, 32'd1);
        chk("done_busy", {31'd0, bus.busy}, 32'd0);
        chk("done_ready", {31'd0, bus.load_byte_ready}, 32'd0);
        for (int w = 0; w < len; w++) begin
            t = {lb[2*w+1], lb[2*w]};
            mem_m[(base + w) % DEPTH] = t[INS_W-1:0];
        end
        tick();
        chk("done_once", {31'd0, bus.load_done}, 32'd0);
    endtask

    task automatic bad_load(input int len);
        bus.load_start = 1'b1;
        bus.load_base  = 6'd3;
        bus.load_len   = (ADDR_W+1)'(len);
        tick();
        bus.load_start = 1'b0;
        chk($sformatf("err_pulse_len%0d", len), {31'd0, bus.load_err}, 32'd1);
        chk("err_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("err_once", {31'd0, bus.load_err}, 32'd0);
        chk("err_stay_run", {31'd0, bus.load_byte_ready}, 32'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.fetch_req       = 1'b0;
        bus.fetch_addr      = '0;
        bus.load_start      = 1'b0;
        bus.load_base       = '0;
        bus.load_len        = '0;
        bus.load_byte       = '0;
        bus.load_byte_valid = 1'b0;
        model_clear();
        last_ins = NOP;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk("rst_ready", {31'd0, bus.load_byte_ready}, 32'd0);
        chk("rst_done", {31'd0, bus.load_done}, 32'd0);
        chk("rst_err", {31'd0, bus.load_err}, 32'd0);
        chk("rst_ins", {19'd0, bus.ins_out}, {19'd0, NOP});
        rst = 1'b0;
        count_clear("clear_cycles");
        fetch_seq(5, 1);

        // Masked top bits of the second word
        lb[0] = 8'h01; lb[1] = 8'h02; lb[2] = 8'h03; lb[3] = 8'hFF;
        do_load(0, 2, 1'b0, 1'b0);
        fetch_seq(0, 2);
        chk("model_w0", {19'd0, mem_m[0]}, 32'h0201);
        chk("model_w1", {19'd0, mem_m[1]}, 32'h1F03);

        // Address wrap from 63 to 0
        lb[0] = 8'hAA; lb[1] = 8'h00; lb[2] = 8'h55; lb[3] = 8'h00;
        do_load(63, 2, 1'b0, 1'b0);
        fetch_seq(63, 3);

        bad_load(0);
        bad_load(65);
        fetch_seq(62, 4);

        // Gapped load with fetches ignored while busy
        lb[0] = 8'h34; lb[1] = 8'h12; lb[2] = 8'h78; lb[3] = 8'h06; lb[4] = 8'hCD; lb[5] = 8'h0B;
        do_load(20, 3, 1'b1, 1'b1);
        fetch_seq(19, 5);

        // Simultaneous fetch and load_start: fetch served, then LOAD
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 6'd21;
        bus.load_start = 1'b1;
        bus.load_base  = 6'd40;
        bus.load_len   = 7'd64;
        tick();
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b0;
        chk("coinc_valid", {31'd0, bus.ins_valid}, 32'd1);
        chk("coinc_data", {19'd0, bus.ins_out}, {19'd0, mem_m[21]});
        chk("coinc_busy", {31'd0, bus.busy}, 32'd1);

        // Reset mid-load after three bytes
        lb[0] = 8'h11; lb[1] = 8'h0A; lb[2] = 8'h22;
        for (int i = 0; i < 3; i++) begin
            bus.load_byte_valid = 1'b1;
            bus.load_byte       = lb[i];
            tick();
        end
        bus.load_byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        count_clear("reclear_cycles");
        fetch_seq(0, DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
